fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, max FETCH wait cycles without ack before fault.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port go_in  in  1  start from IDLE, or resume from HALTED.
REQ-005 SHALL have port halt_in  in  1  request stop after current instruction.
REQ-006 SHALL have port imem_ack_in  in  1  instruction memory data valid on ins bus.
REQ-007 SHALL have port opc_in  in  4  opcode field, ins_out[15:12] of instruction register.
REQ-008 SHALL have port ex_done_in  in  1  execution unit completion.
REQ-009 SHALL have port imem_req_out  out  1  instruction memory read request.
REQ-010 SHALL have port il_out  out  1  instruction register load strobe, drives IR il_in.
REQ-011 SHALL have port pc_inc_out  out  1  program counter increment strobe.
REQ-012 SHALL have port ex_start_out  out  1  execution start pulse.
REQ-013 SHALL have port icount_out  out  16  retired-instruction counter.
REQ-014 SHALL have port state_out  out  3  current FSM state encoding.
REQ-015 SHALL have port fault_out  out  1  sticky fetch-timeout fault.

Function
REQ-016 SHALL implement states IDLE, FETCH, DECODE, EXEC, HALTED, FAULT.
REQ-017 IDLE: go_in=1 -> FETCH next cycle; otherwise stay.
REQ-018 FETCH: imem_req_out=1 every FETCH cycle until ack.
REQ-019 FETCH with imem_ack_in=1: il_out=1 and pc_inc_out=1 combinationally in that same cycle (exactly one cycle), next state DECODE.
REQ-020 Timeout counter SHALL clear on FETCH entry, increment each FETCH cycle without ack; at count==TIMEOUT_CYCLES -> FAULT.
REQ-021 Ack and timeout in same cycle: ack wins, no fault.
REQ-022 DECODE lasts exactly one cycle; icount_out increments by 1, wrapping 16'hFFFF -> 16'h0000.
REQ-023 DECODE, opc_in==OPC_HALT (4'hF) -> HALTED, no ex_start_out.
REQ-024 DECODE, opc_in==OPC_NOP (4'h0) -> FETCH, no ex_start_out.
REQ-025 DECODE, any other opcode: ex_start_out=1 in that cycle, next state EXEC.
REQ-026 EXEC: wait ex_done_in; on ex_done_in=1 -> HALTED if halt pending, else FETCH.
REQ-027 halt_in=1 in any state except IDLE/HALTED/FAULT SHALL set halt_pending; halt_pending cleared on entry to HALTED.
REQ-028 halt_in and ex_done_in in same cycle: halt honored (-> HALTED).
REQ-029 halt_pending in FETCH/DECODE SHALL not abort the instruction; honored only at EXEC completion or NOP/HALT decode (-> HALTED).
REQ-030 HALTED: go_in=1 -> FETCH; otherwise stay; go_in ignored in all other states.
REQ-031 FAULT: fault_out=1, all strobes 0, exit only by rst.
REQ-032 imem_req_out, il_out, pc_inc_out, ex_start_out SHALL be 0 in every state not listed above.

Reset
REQ-033 rst=1 at a rising edge SHALL force IDLE, icount_out=0, fault_out=0, halt_pending=0, timeout counter=0, regardless of state, including mid-FETCH or mid-EXEC.
REQ-034 During and immediately after reset, all strobe outputs SHALL be 0.

Structure
REQ-035 State enum fetch_state_t, OPC_HALT, OPC_NOP, FETCH_TIMEOUT default SHALL live in mycpu_pkg.
REQ-036 The timeout counter SHALL be a sub-module fetch_timer (clear, enable, expired outputs).

Verification
REQ-037 Reset, go_in=1, ack after 2 req cycles with opc 4'h1, ex_done 3 cycles later -> il_out one pulse, ex_start_out one pulse, icount_out=1, back to FETCH.
REQ-038 opc 4'h0 fetched -> DECODE -> FETCH, ex_start_out never 1, icount_out increments.
REQ-039 No ack for 15 FETCH cycles -> fault_out=1, stays after go_in; ack on 15th cycle -> no fault.
REQ-040 halt_in pulse during EXEC, ex_done later -> HALTED; go_in=1 -> FETCH, icount_out continues.
REQ-041 Preload icount_out to 16'hFFFF (retire 65535 instructions) then one more -> 16'h0000.
REQ-042 rst asserted mid-EXEC -> next cycle IDLE, icount_out=0, all strobes 0.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// State encodings are visible on state_out, so their values are fixed here.
package mycpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4,
    FAULT  = 3'd5
  } fetch_state_t;

  localparam logic [3:0] OPC_HALT = 4'hF;
  localparam logic [3:0] OPC_NOP  = 4'h0;

  localparam int FETCH_TIMEOUT = 15;

  // True for opcodes that need the execution unit.
  function automatic logic opc_executes(input logic [3:0] opc);
    return (opc != OPC_HALT) && (opc != OPC_NOP);
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Counts consecutive un-acknowledged FETCH cycles; expired flags the cycle
// that would be the LIMIT-th such cycle.
module fetch_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_reg;

  assign expired = enable && (count_reg == LAST);

  // Saturate at LAST: the sequencer leaves FETCH on expiry anyway.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode/execute sequencer with halt handling, a fetch
// timeout fault and a retired-instruction counter.
module fetch_sequencer
  import mycpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = FETCH_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go_in,
  input  logic        halt_in,
  input  logic        imem_ack_in,
  input  logic [3:0]  opc_in,
  input  logic        ex_done_in,
  output logic        imem_req_out,
  output logic        il_out,
  output logic        pc_inc_out,
  output logic        ex_start_out,
  output logic [15:0] icount_out,
  output logic [2:0]  state_out,
  output logic        fault_out
);

  fetch_state_t state_reg, state_next;
  logic         halt_pending_reg, halt_pending_next;
  logic [15:0]  icount_reg;
  logic         halt_now;
  logic         timer_expired;

  fetch_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_reg != FETCH),
    .enable  ((state_reg == FETCH) && !imem_ack_in),
    .expired (timer_expired)
  );

  always_comb begin
    state_next   = state_reg;
    imem_req_out = 1'b0;
    il_out       = 1'b0;
    pc_inc_out   = 1'b0;
    ex_start_out = 1'b0;
    halt_now     = halt_pending_reg || halt_in;

    case (state_reg)
      IDLE:   if (go_in) state_next = FETCH;
      FETCH: begin
        imem_req_out = 1'b1;
        if (imem_ack_in) begin
          il_out     = 1'b1;
          pc_inc_out = 1'b1;
          state_next = DECODE;
        end else if (timer_expired) begin
          state_next = FAULT;
        end
      end
      DECODE: begin
        if (opc_in == OPC_HALT) begin
          state_next = HALTED;
        end else if (!opc_executes(opc_in)) begin
          state_next = halt_now ? HALTED : FETCH;
        end else begin
          ex_start_out = 1'b1;
          state_next   = EXEC;
        end
      end
      EXEC:   if (ex_done_in) state_next = halt_now ? HALTED : FETCH;
      HALTED: if (go_in) state_next = FETCH;
      FAULT:  state_next = FAULT;
      default: state_next = IDLE;
    endcase

    // Strobes stay quiet while reset is held, whatever the current state.
    if (rst) begin
      imem_req_out = 1'b0;
      il_out       = 1'b0;
      pc_inc_out   = 1'b0;
      ex_start_out = 1'b0;
    end

    halt_pending_next = halt_pending_reg;
    if (state_next == HALTED) begin
      halt_pending_next = 1'b0;
    end else if (halt_in && (state_reg == FETCH || state_reg == DECODE || state_reg == EXEC)) begin
      halt_pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      halt_pending_reg <= 1'b0;
      icount_reg       <= '0;
    end else begin
      state_reg        <= state_next;
      halt_pending_reg <= halt_pending_next;
      if (state_reg == DECODE) icount_reg <= icount_reg + 16'd1;
    end
  end

  assign icount_out = icount_reg;
  assign state_out  = state_reg;
  assign fault_out  = (state_reg == FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a per-cycle reference model checked on
// every falling edge, plus literal checkpoints after each scenario.
module tb_fetch_sequencer;

  localparam int TO = 15;
  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_HALTED = 4, P_FAULT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go_in = 1'b0, halt_in = 1'b0, imem_ack_in = 1'b0, ex_done_in = 1'b0;
  logic [3:0]  opc_in = 4'h0;
  logic        imem_req_out, il_out, pc_inc_out, ex_start_out, fault_out;
  logic [15:0] icount_out;
  logic [2:0]  state_out;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;
  int il_n = 0;
  int ex_n = 0;

  // reference model
  int m_ph = P_IDLE;
  int m_wait = 0;
  int m_cnt = 0;
  bit m_hp = 1'b0;

  fetch_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .go_in        (go_in),
    .halt_in      (halt_in),
    .imem_ack_in  (imem_ack_in),
    .opc_in       (opc_in),
    .ex_done_in   (ex_done_in),
    .imem_req_out (imem_req_out),
    .il_out       (il_out),
    .pc_inc_out   (pc_inc_out),
    .ex_start_out (ex_start_out),
    .icount_out   (icount_out),
    .state_out    (state_out),
    .fault_out    (fault_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int nxt;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_ph = P_IDLE; m_wait = 0; m_cnt = 0; m_hp = 1'b0;
      end else begin
        nxt = m_ph;
        case (m_ph)
          P_IDLE:   if (go_in) nxt = P_FETCH;
          P_FETCH: begin
            if (imem_ack_in) nxt = P_DECODE;
            else begin
              m_wait++;
              if (m_wait == TO) nxt = P_FAULT;
            end
          end
          P_DECODE: begin
            m_cnt = (m_cnt + 1) % 65536;
            if (opc_in == 4'hF) nxt = P_HALTED;
            else if (opc_in == 4'h0) nxt = (m_hp || halt_in) ? P_HALTED : P_FETCH;
            else nxt = P_EXEC;
          end
          P_EXEC:   if (ex_done_in) nxt = (m_hp || halt_in) ? P_HALTED : P_FETCH;
          P_HALTED: if (go_in) nxt = P_FETCH;
          default:  nxt = m_ph;
        endcase
        if (nxt == P_HALTED) m_hp = 1'b0;
        else if (halt_in && (m_ph == P_FETCH || m_ph == P_DECODE || m_ph == P_EXEC)) m_hp = 1'b1;
        if (nxt == P_FETCH && m_ph != P_FETCH) m_wait = 0;
        m_ph = nxt;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("state", 32'(state_out), 32'(m_ph));
      chk("imem_req", 32'(imem_req_out), 32'(!rst && m_ph == P_FETCH));
      chk("il", 32'(il_out), 32'(!rst && m_ph == P_FETCH && imem_ack_in));
      chk("pc_inc", 32'(pc_inc_out), 32'(!rst && m_ph == P_FETCH && imem_ack_in));
      chk("ex_start", 32'(ex_start_out),
          32'(!rst && m_ph == P_DECODE && opc_in != 4'h0 && opc_in != 4'hF));
      chk("icount", 32'(icount_out), 32'(m_cnt));
      chk("fault", 32'(fault_out), 32'(m_ph == P_FAULT));
      if (il_out) il_n++;
      if (ex_start_out) ex_n++;
    end
  end

  task automatic step(input logic go, input logic halt, input logic ack,
                      input logic [3:0] opc, input logic done);
    go_in = go; halt_in = halt; imem_ack_in = ack; opc_in = opc; ex_done_in = done;
    @(posedge clk);
    #1;
  endtask

  // waits un-acked FETCH cycles, one acked cycle, then the DECODE cycle
  task automatic fetch_instr(input int waits, input logic [3:0] opc);
    for (int i = 0; i < waits; i++) step(1'b0, 1'b0, 1'b0, opc, 1'b0);
    step(1'b0, 1'b0, 1'b1, opc, 1'b0);
    step(1'b0, 1'b0, 1'b0, opc, 1'b0);
    $display("txn fetch opc=%h waits=%0d icount=%0d state=%0d", opc, waits, icount_out, state_out);
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    cmp_on = 1'b1;
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    chk("reset_state", 32'(state_out), 32'd0);
    chk("reset_icount", 32'(icount_out), 32'd0);
    chk("reset_fault", 32'(fault_out), 32'd0);
    rst = 1'b0;

    // halt in IDLE must not arm a pending halt
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    fetch_instr(2, 4'h1);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    $display("txn exec opc=1 icount=%0d state=%0d", icount_out, state_out);
    chk("basic_il_pulses", 32'(il_n), 32'd1);
    chk("basic_ex_pulses", 32'(ex_n), 32'd1);
    chk("basic_icount", 32'(icount_out), 32'd1);
    chk("basic_state", 32'(state_out), 32'd1);

    fetch_instr(0, 4'h0);
    chk("nop_ex_pulses", 32'(ex_n), 32'd1);
    chk("nop_icount", 32'(icount_out), 32'd2);
    chk("nop_state", 32'(state_out), 32'd1);

    // halt pulse during EXEC, done later
    fetch_instr(1, 4'h3);
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    chk("halt_exec_state", 32'(state_out), 32'd4);
    chk("halt_exec_icount", 32'(icount_out), 32'd3);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    fetch_instr(0, 4'h2);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    $display("txn resume icount=%0d state=%0d", icount_out, state_out);
    chk("resume_icount", 32'(icount_out), 32'd4);
    chk("resume_state", 32'(state_out), 32'd1);

    // halt and done together
    fetch_instr(0, 4'h5);
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    chk("halt_done_same_state", 32'(state_out), 32'd4);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);

    // halt during FETCH does not abort the instruction
    step(1'b0, 1'b1, 1'b0, 4'h7, 1'b0);
    fetch_instr(0, 4'h7);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    chk("halt_fetch_state", 32'(state_out), 32'd4);
    chk("halt_fetch_ex_pulses", 32'(ex_n), 32'd5);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);

    fetch_instr(0, 4'hF);
    chk("opc_halt_state", 32'(state_out), 32'd4);
    chk("opc_halt_ex_pulses", 32'(ex_n), 32'd5);
    chk("opc_halt_icount", 32'(icount_out), 32'd7);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);

    // ack on the 15th FETCH cycle wins over the timeout
    fetch_instr(TO - 1, 4'h0);
    chk("late_ack_fault", 32'(fault_out), 32'd0);
    chk("late_ack_icount", 32'(icount_out), 32'd8);

    for (int i = 0; i < TO; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    $display("txn timeout state=%0d fault=%0d", state_out, fault_out);
    chk("timeout_state", 32'(state_out), 32'd5);
    chk("timeout_fault", 32'(fault_out), 32'd1);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'h0, 1'b0);
    chk("fault_sticky", 32'(fault_out), 32'd1);
    chk("fault_no_req", 32'(imem_req_out), 32'd0);

    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    chk("fault_reset_state", 32'(state_out), 32'd0);
    chk("fault_reset_fault", 32'(fault_out), 32'd0);

    // reset mid-FETCH with ack present
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
    rst = 1'b0;
    chk("fetch_reset_state", 32'(state_out), 32'd0);

    // reset mid-EXEC
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    fetch_instr(0, 4'h1);
    chk("pre_reset_icount", 32'(icount_out), 32'd1);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    rst = 1'b0;
    $display("txn reset_exec state=%0d icount=%0d", state_out, icount_out);
    chk("exec_reset_state", 32'(state_out), 32'd0);
    chk("exec_reset_icount", 32'(icount_out), 32'd0);
    chk("exec_reset_req", 32'(imem_req_out), 32'd0);
    chk("exec_reset_ex", 32'(ex_start_out), 32'd0);

    // counter wrap: load the count that 65535 retirements would leave
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    dut.icount_reg <= 16'hFFFF;
    m_cnt = 65535;
    #1;
    chk("preload_icount", 32'(icount_out), 32'h0000_FFFF);
    fetch_instr(0, 4'h0);
    chk("wrap_icount", 32'(icount_out), 32'd0);
    fetch_instr(0, 4'h0);
    chk("post_wrap_icount", 32'(icount_out), 32'd1);

    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
